arm_shift_pipe: RTL

- Parametrised, pipelined successor of the combinational ARM barrel shifter.
- Implements full ARM data-processing shifter-operand semantics:
  - LSL, LSR, ASR, ROR, RRX.
  - Immediate-encoded and register-specified amounts, including zero and out-of-range amounts.
  - Carry-out generation.
- Sits between operand fetch and the ALU. Uses valid/ready handshakes on both sides so the ALU can stall it.

---
 rtl/arm_shift_pipe.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/arm_shift_pipe.sv
// arm_shift_pipe: two-stage pipelined ARM shifter-operand unit.
// Stage 1 captures the request and decodes the effective operation.
// Stage 2 holds the shifted result and carry-out.
// Both stages use valid/ready handshakes so the ALU can stall the pipe.
`timescale 1ns/1ps
module arm_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_imm,
    input  logic             in_cin,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    localparam int LG = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] AMT_N = AMT_W'(WIDTH);

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;

    // Amount class: in range (0 < a < N), exactly N, or beyond N.
    typedef enum logic [1:0] {
        CLS_IN = 2'd0,
        CLS_EQ = 2'd1,
        CLS_GT = 2'd2
    } amt_cls_t;

    // Shift/rotate of an already-decoded operation; returns {cout, result}.
    function automatic logic [WIDTH:0] shift_core(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       typ,
        input amt_cls_t         cls,
        input logic [LG-1:0]    sh,
        input logic             cin,
        input logic             pass,
        input logic             rrx
    );
        logic signed [WIDTH-1:0] xs;
        logic [LG-1:0]           top_idx;
        logic [LG-1:0]           low_idx;
        logic [WIDTH-1:0]        res;
        logic                    c;
        xs      = $signed(x);
        // N - sh wraps naturally in LG bits because sh is never 0 when used.
        top_idx = {LG{1'b0}} - sh;
        low_idx = sh - {{(LG-1){1'b0}}, 1'b1};
        res     = x;
        c       = cin;
        if (!pass) begin
            if (rrx) begin
                res = {cin, x[WIDTH-1:1]};
                c   = x[0];
            end else begin
                case (typ)
                    T_LSL: begin
                        case (cls)
                            CLS_IN:  begin res = x << sh; c = x[top_idx]; end
                            CLS_EQ:  begin res = '0;      c = x[0];       end
                            default: begin res = '0;      c = 1'b0;       end
                        endcase
                    end
                    T_LSR: begin
                        case (cls)
                            CLS_IN:  begin res = x >> sh; c = x[low_idx];   end
                            CLS_EQ:  begin res = '0;      c = x[WIDTH-1];   end
                            default: begin res = '0;      c = 1'b0;         end
                        endcase
                    end
                    T_ASR: begin
                        if (cls == CLS_IN) begin
                            res = xs >>> sh;
                            c   = x[low_idx];
                        end else begin
                            res = {WIDTH{x[WIDTH-1]}};
                            c   = x[WIDTH-1];
                        end
                    end
                    default: begin
                        // Rotate amount is already reduced mod N; 0 here means a
                        // nonzero multiple of N.
                        if (sh == {LG{1'b0}}) begin
                            res = x;
                            c   = x[WIDTH-1];
                        end else begin
                            res = (x >> sh) | (x << (WIDTH - int'(sh)));
                            c   = x[low_idx];
                        end
                    end
                endcase
            end
        end
        return {c, res};
    endfunction

    // Decode outputs
    logic            dec_pass;
    logic            dec_rrx;
    amt_cls_t        dec_cls;
    logic [LG-1:0]   dec_sh;

    // Stage 1 registers
    logic             vld_p1;
    logic [WIDTH-1:0] x_p1;
    logic [1:0]       typ_p1;
    amt_cls_t         cls_p1;
    logic [LG-1:0]    sh_p1;
    logic             cin_p1;
    logic             pass_p1;
    logic             rrx_p1;

    // Stage 2 registers
    logic             vld_p2;
    logic [WIDTH-1:0] data_p2;
    logic             cout_p2;

    logic             adv_p2;
    logic [WIDTH:0]   core_res;

    assign adv_p2    = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || adv_p2;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_cout  = cout_p2;
    assign core_res  = shift_core(x_p1, typ_p1, cls_p1, sh_p1, cin_p1, pass_p1, rrx_p1);

    // Decode the effective operation from the raw request fields.
    always_comb begin
        dec_pass = 1'b0;
        dec_rrx  = 1'b0;
        dec_cls  = CLS_IN;
        dec_sh   = in_amt[LG-1:0];
        if (!in_en) begin
            dec_pass = 1'b1;
        end else if (in_imm) begin
            // Immediate #0 re-encodes: LSL#0 pass, LSR/ASR#0 mean #N, ROR#0 is RRX.
            if (in_amt[LG-1:0] == {LG{1'b0}}) begin
                case (in_type)
                    T_LSL:   dec_pass = 1'b1;
                    T_LSR:   dec_cls  = CLS_EQ;
                    T_ASR:   dec_cls  = CLS_EQ;
                    default: dec_rrx  = 1'b1;
                endcase
            end
        end else begin
            if (in_amt == '0) begin
                dec_pass = 1'b1;
            end else if (in_amt < AMT_N) begin
                dec_cls = CLS_IN;
            end else if (in_amt == AMT_N) begin
                dec_cls = CLS_EQ;
            end else begin
                dec_cls = CLS_GT;
            end
        end
    end

    // ---- stage 1: capture request and decoded operation ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            typ_p1  <= '0;
            cls_p1  <= CLS_IN;
            sh_p1   <= '0;
            cin_p1  <= 1'b0;
            pass_p1 <= 1'b0;
            rrx_p1  <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (in_valid && in_ready) begin
                x_p1    <= in_data;
                typ_p1  <= in_type;
                cls_p1  <= dec_cls;
                sh_p1   <= dec_sh;
                cin_p1  <= in_cin;
                pass_p1 <= dec_pass;
                rrx_p1  <= dec_rrx;
            end
        end
    end

    // ---- stage 2: shifted result and carry, held while stalled ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            cout_p2 <= 1'b0;
        end else begin
            if (adv_p2) vld_p2 <= vld_p1;
            if (vld_p1 && adv_p2) begin
                data_p2 <= core_res[WIDTH-1:0];
                cout_p2 <= core_res[WIDTH];
            end
        end
    end

endmodule
